rgb_window_3x3: RTL and testbench
=================================

Name: rgb_window_3x3

Overview:
- Upstream neighbour of the sharpening filter: turns a raster RGB pixel stream into 3x3 RGB neighbourhoods, one per source pixel, in raster order.
- Pixels arrive bottom-up in BMP order, but the block treats the order only as raster.
- Holds two line buffers and a 3-column tap register, replicates pixels at the image borders, and flushes the last row after the final input pixel.
- The downstream kernel then only does arithmetic on 9 taps per channel.

Parameters:
- WIDTH, 8, bits per colour channel.
- DEPTH, 512, line-buffer entries; must be >= COLS.
- LINE_BITS, 10, width of row/column counters and line-buffer address.
- ROWS, 512, image height in pixels.
- COLS, 512, image width in pixels.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- r_data_in  in  WIDTH  red input pixel.
- g_data_in  in  WIDTH  green input pixel.
- b_data_in  in  WIDTH  blue input pixel.
- data_in_done  in  1  input pixel valid strobe; pixel is accepted at a rising edge while high.
- in_ready  out  1  high when input pixels are accepted (IDLE/RUN).
- win_r  out  9*WIDTH  red taps; tap t=3*dy+dx at bits [t*WIDTH +: WIDTH]; dy=0 is the row above, dx=0 the left column, t=4 the centre.
- win_g  out  9*WIDTH  green taps, same packing.
- win_b  out  9*WIDTH  blue taps, same packing.
- win_valid  out  1  window bus valid for one cycle.
- center_row  out  LINE_BITS  row of the centre pixel.
- center_col  out  LINE_BITS  column of the centre pixel.
- frame_done  out  1  one-cycle pulse after the last window of a frame.
- err_overrun  out  1  sticky; input arrived while in_ready was low.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all counters 0.
  - Outputs: win_* = 0, win_valid = 0, center_* = 0, frame_done = 0, err_overrun = 0, in_ready = 1.
  - Line-buffer contents are not cleared; border replication makes stale data invisible.
- Step: an internal advance. It occurs on an accepted input (IDLE/RUN with data_in_done=1) or on every cycle in FLUSH.
  - Each step pushes the column {lb1[col], lb0[col], new pixel} into the 3-column tap register.
  - It writes lb0[col] <= new pixel and lb1[col] <= old lb0[col].
  - Flush steps push zero pixels.
- Step counter s runs 0 .. ROWS*COLS+COLS. A step with s >= COLS+1 produces the window centred at linear index k = s-COLS-1 (row k/COLS, col k%COLS).
- Latency: win_valid rises exactly 2 rising edges after the producing step's edge. This allows a synchronous line-buffer read plus an output register.
- Border replication is applied at the output register, per channel:
  - center_col==0: left taps := centre-column taps.
  - center_col==COLS-1: right taps := centre-column taps.
  - center_row==0: top taps := centre-row taps.
  - center_row==ROWS-1: bottom taps := centre-row taps.
  - Corners apply both rules (the corner tap equals the centre).
- FSM:
  - IDLE: waits for the first accepted pixel (s=0), then -> RUN.
  - RUN: on accepting pixel s=ROWS*COLS-1 -> FLUSH.
  - FLUSH: in_ready=0; COLS+1 steps, one per cycle; after the last step -> DRAIN.
  - DRAIN: waits for the pipeline (2 cycles). frame_done pulses coincident with the cycle after the last win_valid, then -> IDLE with s=0.
- Gaps: data_in_done low in RUN stalls the block; there is no step, and win_valid stays low beyond the pipeline.
- Overrun: data_in_done=1 in FLUSH/DRAIN drops the pixel and sets err_overrun, which holds until reset.
- Reset mid-frame: the frame is abandoned. The next accepted pixel is treated as pixel (0,0) of a new frame.
- Counters wrap: col COLS-1 -> 0 with row+1. The line-buffer address equals the column; there is no modulo beyond COLS.
- Exactly ROWS*COLS windows are emitted per frame.

Decomposition:
- Shared header rgb_window_pkg.vh holds:
  - FSM state codes (IDLE, RUN, FLUSH, DRAIN).
  - Tap index constants (TAP_TL .. TAP_BR, TAP_C=4).
  - PIPE_LAT=2.
- One sub-module, line_buffer_rgb: single-port DEPTH x (3*WIDTH) RAM with synchronous read-before-write. It is instantiated twice (lb0, lb1).

Test Plan:
Use ROWS=4, COLS=4, DEPTH=4, LINE_BITS=3. Input pixels have r=k, g=k+16, b=k+32, where k is the raster index, with data_in_done held high.
- Ramp frame -> 16 win_valid pulses.
  - First window appears 2 edges after accepting k=5: centre (0,0), win_r taps = {0,0,1, 0,0,1, 4,4,5}.
  - Last window is centre (3,3): taps {10,11,11, 14,15,15, 14,15,15}.
  - frame_done pulses once.
- Interior check: centre (1,1) win_r = {0,1,2,4,5,6,8,9,10}, win_g = each value +16, center_row=1, center_col=1.
- Gaps: insert a random 0-3 idle cycles between pixels -> identical window sequence, and no win_valid without a preceding step.
- Overrun: assert data_in_done during FLUSH -> err_overrun=1, window output is unchanged, and err_overrun stays 1 until reset.
- Reset after 7 pixels, then send a full ramp frame -> output identical to the first test, and err_overrun=0.
- Back-to-back frames: start frame 2 on the cycle after frame_done -> the second frame's windows are correct, with no stale taps from frame 1.

Source files
------------

// File: rtl/rgb_window_3x3_pkg.sv
// Shared definitions for the 3x3 RGB window generator.
//   state_t   : FSM state codes (IDLE, RUN, FLUSH, DRAIN)
//   TAP_*     : tap index t = 3*dy + dx inside the packed window bus
//   PIPE_LAT  : edges from a step to its win_valid
package rgb_window_3x3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int TAP_TL   = 0;
    localparam int TAP_TC   = 1;
    localparam int TAP_TR   = 2;
    localparam int TAP_ML   = 3;
    localparam int TAP_C    = 4;
    localparam int TAP_MR   = 5;
    localparam int TAP_BL   = 6;
    localparam int TAP_BC   = 7;
    localparam int TAP_BR   = 8;
    localparam int NUM_TAPS = 9;

    localparam int PIPE_LAT = 2;

endpackage

// File: rtl/rgb_window_3x3_lb.sv
// line_buffer_rgb: single-port DEPTH x (3*WIDTH) RAM, synchronous
// read-before-write. One address serves both the read and the write.
//   clk     : clock
//   i_en    : port enable (read this cycle)
//   i_we    : write enable (only honoured with i_en)
//   i_addr  : entry address
//   i_wdata : {r,g,b} pixel to store
//   o_rdata : registered old contents of i_addr
module line_buffer_rgb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               i_en,
    input  logic               i_we,
    input  logic [AW-1:0]      i_addr,
    input  logic [3*WIDTH-1:0] i_wdata,
    output logic [3*WIDTH-1:0] o_rdata
);

    logic [3*WIDTH-1:0] r_mem [DEPTH];
    logic [3*WIDTH-1:0] r_rdata;

    // No reset: stale contents are never visible after border replication.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rgb_window_3x3.sv
// rgb_window_3x3: turns a raster RGB stream into one 3x3 neighbourhood per
// source pixel, with border replication and an end-of-frame flush.
//   clk, reset            : clock, async active-low reset
//   r/g/b_data_in         : input pixel channels
//   data_in_done          : input strobe, accepted while in_ready
//   in_ready              : high in IDLE/RUN
//   win_r/g/b             : 9 taps per channel, tap t = 3*dy+dx at [t*WIDTH +: WIDTH]
//   win_valid             : window bus valid (one cycle)
//   center_row/center_col : centre pixel coordinates
//   frame_done            : pulse in the cycle after the last window
//   err_overrun           : sticky, input strobe seen while not ready
module rgb_window_3x3
    import rgb_window_3x3_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 512,
    parameter int LINE_BITS = 10,
    parameter int ROWS      = 512,
    parameter int COLS      = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     r_data_in,
    input  logic [WIDTH-1:0]     g_data_in,
    input  logic [WIDTH-1:0]     b_data_in,
    input  logic                 data_in_done,
    output logic                 in_ready,
    output logic [9*WIDTH-1:0]   win_r,
    output logic [9*WIDTH-1:0]   win_g,
    output logic [9*WIDTH-1:0]   win_b,
    output logic                 win_valid,
    output logic [LINE_BITS-1:0] center_row,
    output logic [LINE_BITS-1:0] center_col,
    output logic                 frame_done,
    output logic                 err_overrun
);

    localparam int PW = 3 * WIDTH;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LINE_BITS-1:0] LAST_ROW  = LINE_BITS'(ROWS - 1);
    localparam logic [LINE_BITS-1:0] LAST_COL  = LINE_BITS'(COLS - 1);
    localparam logic [LINE_BITS-1:0] FLUSH_ROW = LINE_BITS'(ROWS + 1);

    // ---------------- control ----------------
    state_t               r_state;
    logic [LINE_BITS-1:0] r_row, r_col;     // position of the current step
    logic [1:0]           r_drain;
    logic                 r_in_ready, r_frame_done, r_err;

    logic                 w_accept, w_step, w_last_in, w_last_flush, w_produce;
    logic [PW-1:0]        w_pix;
    logic [LINE_BITS-1:0] w_crow, w_ccol;

    assign w_accept     = data_in_done && r_in_ready;
    assign w_step       = w_accept || (r_state == ST_FLUSH);
    assign w_pix        = (r_state == ST_FLUSH) ? '0 : {r_data_in, g_data_in, b_data_in};
    assign w_last_in    = (r_row == LAST_ROW) && (r_col == LAST_COL);
    // step s = (ROWS+1)*COLS is the last flush step
    assign w_last_flush = (r_row == FLUSH_ROW) && (r_col == '0);
    // step s >= COLS+1 produces the window centred at s-COLS-1
    assign w_produce    = (r_row > LINE_BITS'(1)) || ((r_row == LINE_BITS'(1)) && (r_col != '0));

    always_comb begin
        if (r_col == '0) begin
            w_crow = r_row - LINE_BITS'(2);
            w_ccol = LAST_COL;
        end else begin
            w_crow = r_row - LINE_BITS'(1);
            w_ccol = r_col - LINE_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_drain      <= '0;
            r_in_ready   <= 1'b1;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (data_in_done && !r_in_ready) begin
                r_err <= 1'b1;
            end
            if (w_step) begin
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + LINE_BITS'(1);
                end else begin
                    r_col <= r_col + LINE_BITS'(1);
                end
            end
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_accept) begin
                        if (w_last_in) begin
                            r_state    <= ST_FLUSH;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_last_flush) begin
                        r_state <= ST_DRAIN;
                        r_drain <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == 2'(PIPE_LAT)) begin
                        r_state      <= ST_IDLE;
                        r_in_ready   <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_row        <= '0;
                        r_col        <= '0;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- line buffers ----------------
    // Rows ping-pong between the two RAMs by row parity: the RAM matching the
    // current row's parity holds row-2, the other holds row-1. The taps see
    // the same data as shifting lb0 into lb1, but no RAM-to-RAM copy is
    // needed, so each RAM keeps one address per cycle.
    logic [AW-1:0] w_addr;
    logic [PW-1:0] w_rd0, w_rd1;

    assign w_addr = AW'(r_col);

    line_buffer_rgb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_lb0 (
        .clk    (clk),
        .i_en   (w_step),
        .i_we   (w_step && !r_row[0]),
        .i_addr (w_addr),
        .i_wdata(w_pix),
        .o_rdata(w_rd0)
    );

    line_buffer_rgb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_lb1 (
        .clk    (clk),
        .i_en   (w_step),
        .i_we   (w_step && r_row[0]),
        .i_addr (w_addr),
        .i_wdata(w_pix),
        .o_rdata(w_rd1)
    );

    // ---------------- stage 1: RAM read in flight ----------------
    logic                 r_vld1, r_prod1, r_par1;
    logic [PW-1:0]        r_pix1;
    logic [LINE_BITS-1:0] r_crow1, r_ccol1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld1  <= 1'b0;
            r_prod1 <= 1'b0;
            r_par1  <= 1'b0;
            r_pix1  <= '0;
            r_crow1 <= '0;
            r_ccol1 <= '0;
        end else begin
            r_vld1  <= w_step;
            r_prod1 <= w_step && w_produce;
            if (w_step) begin
                r_par1  <= r_row[0];
                r_pix1  <= w_pix;
                r_crow1 <= w_crow;
                r_ccol1 <= w_ccol;
            end
        end
    end

    logic [PW-1:0] w_top, w_mid;
    assign w_top = r_par1 ? w_rd1 : w_rd0;
    assign w_mid = r_par1 ? w_rd0 : w_rd1;

    // ---------------- stage 2: 3-column tap register ----------------
    logic [PW-1:0]        r_tap [3][3];     // [dx][dy]
    logic                 r_prod2;
    logic [LINE_BITS-1:0] r_crow2, r_ccol2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int dx = 0; dx < 3; dx++) begin
                for (int dy = 0; dy < 3; dy++) begin
                    r_tap[dx][dy] <= '0;
                end
            end
            r_prod2 <= 1'b0;
            r_crow2 <= '0;
            r_ccol2 <= '0;
        end else begin
            r_prod2 <= r_prod1;
            if (r_vld1) begin
                for (int dy = 0; dy < 3; dy++) begin
                    r_tap[0][dy] <= r_tap[1][dy];
                    r_tap[1][dy] <= r_tap[2][dy];
                end
                r_tap[2][0] <= w_top;
                r_tap[2][1] <= w_mid;
                r_tap[2][2] <= r_pix1;
                r_crow2     <= r_crow1;
                r_ccol2     <= r_ccol1;
            end
        end
    end

    // ---------------- stage 3: border replication + output ----------------
    logic [1:0]    w_sx [3];
    logic [1:0]    w_sy [3];
    logic [PW-1:0] w_sel [NUM_TAPS];

    always_comb begin
        w_sx[0] = (r_ccol2 == '0)       ? 2'd1 : 2'd0;
        w_sx[1] = 2'd1;
        w_sx[2] = (r_ccol2 == LAST_COL) ? 2'd1 : 2'd2;
        w_sy[0] = (r_crow2 == '0)       ? 2'd1 : 2'd0;
        w_sy[1] = 2'd1;
        w_sy[2] = (r_crow2 == LAST_ROW) ? 2'd1 : 2'd2;
        for (int t = 0; t < NUM_TAPS; t++) begin
            w_sel[t] = r_tap[w_sx[t % 3]][w_sy[t / 3]];
        end
    end

    logic [9*WIDTH-1:0]   r_win_r, r_win_g, r_win_b;
    logic                 r_win_valid;
    logic [LINE_BITS-1:0] r_crow_o, r_ccol_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_r     <= '0;
            r_win_g     <= '0;
            r_win_b     <= '0;
            r_win_valid <= 1'b0;
            r_crow_o    <= '0;
            r_ccol_o    <= '0;
        end else begin
            r_win_valid <= r_prod2;
            if (r_prod2) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    r_win_r[t*WIDTH +: WIDTH] <= w_sel[t][2*WIDTH +: WIDTH];
                    r_win_g[t*WIDTH +: WIDTH] <= w_sel[t][WIDTH +: WIDTH];
                    r_win_b[t*WIDTH +: WIDTH] <= w_sel[t][0 +: WIDTH];
                end
                r_crow_o <= r_crow2;
                r_ccol_o <= r_ccol2;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign win_r       = r_win_r;
    assign win_g       = r_win_g;
    assign win_b       = r_win_b;
    assign win_valid   = r_win_valid;
    assign center_row  = r_crow_o;
    assign center_col  = r_ccol_o;
    assign frame_done  = r_frame_done;
    assign err_overrun = r_err;

endmodule

// File: tb/tb_rgb_window_3x3.sv
module tb_rgb_window_3x3;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int LB = 3;
    localparam int NW = R * C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  rin = '0, gin = '0, bin = '0;
    logic          dv = 1'b0;
    logic          in_ready, win_valid, frame_done, err_overrun;
    logic [9*W-1:0] win_r, win_g, win_b;
    logic [LB-1:0] center_row, center_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_window_3x3 #(.WIDTH(W), .DEPTH(D), .LINE_BITS(LB), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .reset(rst_n),
        .r_data_in(rin), .g_data_in(gin), .b_data_in(bin), .data_in_done(dv),
        .in_ready(in_ready), .win_r(win_r), .win_g(win_g), .win_b(win_b),
        .win_valid(win_valid), .center_row(center_row), .center_col(center_col),
        .frame_done(frame_done), .err_overrun(err_overrun)
    );

    // capture of every window, tagged with whether an accept happened
    // exactly two edges earlier and which red value it carried
    typedef struct {
        logic [9*W-1:0] r, g, b;
        logic [LB-1:0]  row, col;
        logic           acc;
        int             src;
    } win_t;

    win_t       q[$];
    int         done_cnt = 0;
    logic [2:0] acc_h = '0;
    int         src_h [3] = '{0, 0, 0};

    always @(posedge clk) begin
        acc_h    <= {acc_h[1:0], dv & in_ready};
        src_h[0] <= int'(rin);
        src_h[1] <= src_h[0];
        src_h[2] <= src_h[1];
    end

    always @(negedge clk) begin
        if (win_valid) q.push_back('{win_r, win_g, win_b, center_row, center_col, acc_h[2], src_h[2]});
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    // clamped-coordinate reference window
    function automatic logic [9*W-1:0] exp_win(input int base, input int k, input int ch);
        logic [9*W-1:0] res;
        int r0, c0, rr, cc, v;
        res = '0;
        r0 = k / C;
        c0 = k % C;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                rr = r0 + dy - 1;
                cc = c0 + dx - 1;
                if (rr < 0) rr = 0;
                if (rr > R - 1) rr = R - 1;
                if (cc < 0) cc = 0;
                if (cc > C - 1) cc = C - 1;
                v = base + rr * C + cc + 16 * ch;
                res[(3*dy+dx)*W +: W] = v[W-1:0];
            end
        end
        return res;
    endfunction

    function automatic logic [9*W-1:0] pack9(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7,
                                             input int a8);
        int v [9];
        logic [9*W-1:0] res;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        res = '0;
        for (int t = 0; t < 9; t++) res[t*W +: W] = W'(v[t]);
        return res;
    endfunction

    task automatic send_frame(input int base, input int max_gap, input int npix);
        for (int k = 0; k < npix; k++) begin
            rin = W'(base + k);
            gin = W'(base + k + 16);
            bin = W'(base + k + 32);
            dv  = 1'b1;
            @(posedge clk); #1;
            dv  = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 300 && done_cnt < target; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
        checks++; if ((win_r | win_g | win_b) !== '0) begin errors++; $display("FAIL reset_taps got %h want 0", win_r | win_g | win_b); end
        checks++; if (frame_done !== 1'b0 || err_overrun !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%b err=%b want 0 0", frame_done, err_overrun); end
        checks++; if (center_row !== '0 || center_col !== '0) begin errors++; $display("FAIL reset_center got %0d,%0d want 0,0", center_row, center_col); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp;
        int d0;
        q.delete();
        d0 = done_cnt;
        send_frame(0, 0, NW);
        wait_frames(d0 + 1);
        checks++; if (q.size() != NW) begin errors++; $display("FAIL ramp_count got %0d want %0d", q.size(), NW); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ramp_frame_done got %0d pulses want 1", done_cnt - d0); end
        if (q.size() >= NW) begin
            checks++; if (q[0].r !== pack9(0,0,1, 0,0,1, 4,4,5) || q[0].row !== 0 || q[0].col !== 0)
                begin errors++; $display("FAIL ramp_first got r=%h (%0d,%0d) want %h (0,0)", q[0].r, q[0].row, q[0].col, pack9(0,0,1,0,0,1,4,4,5)); end
            checks++; if (q[0].acc !== 1'b1 || q[0].src != 5)
                begin errors++; $display("FAIL ramp_first_latency got acc=%b src=%0d want acc=1 src=5", q[0].acc, q[0].src); end
            checks++; if (q[NW-1].r !== pack9(10,11,11, 14,15,15, 14,15,15) || q[NW-1].row !== 3 || q[NW-1].col !== 3)
                begin errors++; $display("FAIL ramp_last got r=%h (%0d,%0d) want %h (3,3)", q[NW-1].r, q[NW-1].row, q[NW-1].col, pack9(10,11,11,14,15,15,14,15,15)); end
            for (int i = 0; i < NW; i++) begin
                checks++;
                if (q[i].r !== exp_win(0, i, 0) || q[i].g !== exp_win(0, i, 1) || q[i].b !== exp_win(0, i, 2) ||
                    q[i].row !== LB'(i / C) || q[i].col !== LB'(i % C)) begin
                    errors++;
                    $display("FAIL ramp_win%0d got r=%h g=%h b=%h (%0d,%0d) want r=%h g=%h b=%h", i, q[i].r, q[i].g, q[i].b,
                             q[i].row, q[i].col, exp_win(0, i, 0), exp_win(0, i, 1), exp_win(0, i, 2));
                end
            end
        end
    endtask

    // uses the windows captured by test_ramp
    task automatic test_interior;
        if (q.size() >= NW) begin
            checks++; if (q[5].r !== pack9(0,1,2, 4,5,6, 8,9,10))
                begin errors++; $display("FAIL interior_r got %h want %h", q[5].r, pack9(0,1,2,4,5,6,8,9,10)); end
            checks++; if (q[5].g !== pack9(16,17,18, 20,21,22, 24,25,26))
                begin errors++; $display("FAIL interior_g got %h want %h", q[5].g, pack9(16,17,18,20,21,22,24,25,26)); end
            checks++; if (q[5].row !== 1 || q[5].col !== 1)
                begin errors++; $display("FAIL interior_center got (%0d,%0d) want (1,1)", q[5].row, q[5].col); end
        end else begin
            checks++; errors++; $display("FAIL interior_missing got %0d windows want %0d", q.size(), NW);
        end
    endtask

    task automatic test_gaps;
        int d0;
        q.delete();
        d0 = done_cnt;
        send_frame(0, 3, NW);
        wait_frames(d0 + 1);
        checks++; if (q.size() != NW) begin errors++; $display("FAIL gaps_count got %0d want %0d", q.size(), NW); end
        if (q.size() >= NW) begin
            for (int i = 0; i < NW; i++) begin
                checks++;
                if (q[i].r !== exp_win(0, i, 0) || q[i].g !== exp_win(0, i, 1) || q[i].b !== exp_win(0, i, 2) ||
                    q[i].row !== LB'(i / C) || q[i].col !== LB'(i % C)) begin
                    errors++; $display("FAIL gaps_win%0d got r=%h (%0d,%0d) want r=%h", i, q[i].r, q[i].row, q[i].col, exp_win(0, i, 0));
                end
                // windows 0..NW-C-2 come from accepted pixels, the rest from flush
                checks++;
                if ((i <= NW - C - 2) ? (q[i].acc !== 1'b1 || q[i].src != i + C + 1) : (q[i].acc !== 1'b0)) begin
                    errors++; $display("FAIL gaps_step%0d got acc=%b src=%0d want step from pixel %0d", i, q[i].acc, q[i].src, i + C + 1);
                end
            end
        end
    endtask

    task automatic test_overrun;
        int d0;
        q.delete();
        d0 = done_cnt;
        send_frame(0, 0, NW);
        // block is now flushing
        rin = 8'hAA; gin = 8'hBB; bin = 8'hCC; dv = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        dv = 1'b0;
        @(negedge clk);
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", err_overrun); end
        wait_frames(d0 + 1);
        checks++; if (q.size() != NW) begin errors++; $display("FAIL overrun_count got %0d want %0d", q.size(), NW); end
        if (q.size() >= NW) begin
            for (int i = 0; i < NW; i++) begin
                checks++;
                if (q[i].r !== exp_win(0, i, 0) || q[i].g !== exp_win(0, i, 1) || q[i].b !== exp_win(0, i, 2)) begin
                    errors++; $display("FAIL overrun_win%0d got r=%h want r=%h", i, q[i].r, exp_win(0, i, 0));
                end
            end
        end
        repeat (10) @(negedge clk);
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", err_overrun); end
    endtask

    task automatic test_reset_mid;
        send_frame(0, 0, 7);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL midreset_err got %b want 0", err_overrun); end
        checks++; if (in_ready !== 1'b1 || win_valid !== 1'b0) begin errors++; $display("FAIL midreset_state got rdy=%b vld=%b want 1 0", in_ready, win_valid); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_ramp();
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL midreset_err_after got %b want 0", err_overrun); end
    endtask

    task automatic test_back_to_back;
        bit seen;
        q.delete();
        send_frame(0, 0, NW);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_frame1_done got timeout want pulse"); end
        @(posedge clk); #1;
        send_frame(100, 0, NW);
        for (int i = 0; i < 300 && !frame_done; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (q.size() != 2 * NW) begin errors++; $display("FAIL b2b_count got %0d want %0d", q.size(), 2 * NW); end
        if (q.size() >= 2 * NW) begin
            for (int i = 0; i < 2 * NW; i++) begin
                checks++;
                if (q[i].r !== exp_win((i < NW) ? 0 : 100, i % NW, 0) || q[i].g !== exp_win((i < NW) ? 0 : 100, i % NW, 1) ||
                    q[i].b !== exp_win((i < NW) ? 0 : 100, i % NW, 2) || q[i].row !== LB'((i % NW) / C) || q[i].col !== LB'(i % C)) begin
                    errors++; $display("FAIL b2b_win%0d got r=%h (%0d,%0d) want r=%h", i, q[i].r, q[i].row, q[i].col,
                                       exp_win((i < NW) ? 0 : 100, i % NW, 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_interior();
        test_gaps();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
